tt_serial_tx_nibble: RTL and testbench
======================================

# tt_serial_tx_nibble

Serial framing transmitter tile. It latches a 4-bit nibble from the input pins and shifts it out LSB-first on a single line: start bit, data bits, an optional even-parity bit (XOR of the data), then a stop bit. It is the transmit end of the team's mux/XOR/latch datapath tiles: its `txd` line drives the data pins of a receiving tile. It sits in a TinyTapeout user slot behind the standard 8-in/8-out pin interface.

## Interface
Parameters:
- `DIV`, default 4: clocks per transmitted bit; legal range 1..16; internal divider is 4 bits wide.

Ports, all in the slot's `io_in`/`io_out` buses:
- `io_in[0]`, input, 1 bit: clock; all state updates on its rising edge.
- `io_in[1]`, input, 1 bit: reset, synchronous, active-low.
- `io_in[2]`, input, 1 bit: `start`; a frame is requested on its 0→1 transition.
- `io_in[3]`, input, 1 bit: unused; ignored.
- `io_in[7:4]`, input, 4 bits: data nibble; sampled on the accepting edge only.
- `io_out[0]`, output, 1 bit: `txd`; idle high.
- `io_out[1]`, output, 1 bit: `busy`; high while a frame is on the line.
- `io_out[2]`, output, 1 bit: `done`; one-cycle pulse after the stop bit.
- `io_out[3]`, output, 1 bit: parity (XOR) of the latched nibble.
- `io_out[7:4]`, output, 4 bits: latched nibble.

## Operation
- All outputs are registered.
- Reset values: `txd`=1, `busy`=0, `done`=0, parity=0, nibble=0. The divider, bit index, state and start-edge register are all cleared.
- Start edge detection: `start_q` registers `io_in[2]` every cycle, including while busy. An edge is `io_in[2] & ~start_q`.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: on an edge, latch the nibble and its parity, go to START.
  - START: `txd`=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: `txd`=nibble[idx] for DIV cycles each; idx runs 0..3, then go to PAR (or STOP when parity is compiled out).
  - PAR: `txd`=parity for DIV cycles, then go to STOP.
  - STOP: `txd`=1 for DIV cycles, then go to IDLE and pulse `done`.
- `busy` is 1 in every state except IDLE.
- Edges seen while busy are discarded, not queued. A level held high never retriggers.
- Back-to-back frames: an edge sampled in the `done` cycle (IDLE) is accepted. `txd` falls on the next edge, so there is no idle gap beyond that cycle.
- Reset low mid-frame aborts the frame: the next edge returns all outputs to reset values, with no `done` pulse.
- `io_out[7:4]` and `io_out[3]` hold the last latched values after the frame ends, until the next accept or reset.

## Timing
- Let the edge be sampled at clock edge k, and let F = number of frame bits (7 with parity, 6 without).
- `busy`=1 and `txd`=0 from edge k+1.
- Bit n (0 = start bit) occupies edges k+1+n·DIV through k+(n+1)·DIV.
- At edge k+1+F·DIV: `busy`=0, `done`=1, `txd`=1. `done` returns to 0 one cycle later.
- Frame occupancy is F·DIV cycles. With DIV=1, consecutive bits change `txd` every cycle.

## Configuration
- `TX_PARITY_EN` defined: the PAR state exists, F=7, and the frame is start, d0..d3, parity, stop.
- `TX_PARITY_EN` undefined: PAR is removed, DATA goes directly to STOP, and F=6.
  - `io_out[3]` still reports the XOR of the latched nibble (status only; it is not transmitted).

## Test plan
All scenarios use DIV=4 with `TX_PARITY_EN` defined unless noted.
- Reset: hold `rst_n`=0 for 2 cycles with any inputs → `io_out`=8'b0000_0001. Raise reset with `start`=1 already high → no frame starts.
- Nibble 0xA with a `start` pulse:
  - `txd` = 0,0,1,0,1,0,1, each bit held 4 cycles.
  - `busy` high for 28 cycles, then `done` high for 1 cycle.
  - `io_out[7:4]`=4'hA and `io_out[3]`=0 for the whole frame.
- Nibble 0x7 → `txd` = 0,1,1,1,0,1,1 and `io_out[3]`=1.
- Second `start` edge at cycle 10 of a frame, with `start` then held high → frame unchanged, no second frame, exactly one `done`.
- Edge presented in the `done` cycle with nibble 0x3 → `txd`=0 on the next edge, and a second 28-cycle frame follows.
- `rst_n`=0 during bit 3 → next edge gives `txd`=1, `busy`=0, `done`=0 and never pulses.
- `TX_PARITY_EN` undefined, nibble 0xA → `txd` = 0,0,1,0,1,1 and `busy` high for 24 cycles.

Source files
------------

// File: rtl/tt_serial_tx_nibble.sv
// -----------------------------------------------------------------------------
// tt_serial_tx_nibble
//
// Serial framing transmitter for a TinyTapeout user slot. On a rising edge of
// `start` it latches a 4-bit nibble and shifts it out LSB-first on `txd`:
// start bit (0), d0..d3, optional even-parity bit, stop bit (1). Each bit is
// held for DIV clocks.
//
// Configuration macro: TX_PARITY_EN
//   defined   : parity bit transmitted, frame is 7 bits
//   undefined : parity bit omitted, frame is 6 bits (io_out[3] still reports
//               the XOR of the latched nibble as status)
//
// Parameters:
//   DIV        clocks per bit, 1..16 (divider is 4 bits wide)
//
// Ports:
//   io_in[0]   clock (rising edge)
//   io_in[1]   reset, synchronous, active-low
//   io_in[2]   start; a frame is requested on its 0->1 transition
//   io_in[3]   unused
//   io_in[7:4] data nibble, sampled on the accepting edge only
//   io_out[0]  txd, idle high
//   io_out[1]  busy, high while a frame is on the line
//   io_out[2]  done, one-cycle pulse after the stop bit
//   io_out[3]  parity (XOR) of the latched nibble
//   io_out[7:4] latched nibble
// -----------------------------------------------------------------------------
module tt_serial_tx_nibble #(
  parameter int DIV = 4
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  if (DIV < 1 || DIV > 16) begin : g_div_check
    $error("DIV must be in 1..16");
  end

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [3:0] data_i;
  logic       unused_pin;

  assign clk        = io_in[0];
  assign rst_n      = io_in[1];
  assign start_i    = io_in[2];
  assign unused_pin = io_in[3];
  assign data_i     = io_in[7:4];

  state_e     state_q;
  logic [3:0] div_q;
  logic [1:0] idx_q;
  logic       start_q;
  logic       txd_q;
  logic       busy_q;
  logic       done_q;
  logic       par_q;
  logic [3:0] nib_q;

  logic start_edge_d;
  logic bit_end_d;

  assign start_edge_d = start_i & ~start_q;
  assign bit_end_d    = (div_q == DIV_LAST);

  // NOTE: every register here is updated with <=, so all branches see the
  // pre-edge values of the state and the update order inside the block does
  // not matter.
  always_ff @(posedge clk) begin
    // The edge register follows the pin in every cycle, reset included, so a
    // start level already high when reset is released is not seen as an edge.
    start_q <= start_i;

    // NOTE: reset is sampled on the clock edge only; there is no reset arc in
    // the sensitivity list.
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= 4'd0;
      idx_q   <= 2'd0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      par_q   <= 1'b0;
      nib_q   <= 4'd0;
    end else begin
      done_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          // Edges seen while busy fall through the other states and are lost.
          if (start_edge_d) begin
            nib_q   <= data_i;
            par_q   <= ^data_i;
            state_q <= S_START;
            div_q   <= 4'd0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        default: begin
          if (!bit_end_d) begin
            div_q <= div_q + 4'd1;
          end else begin
            div_q <= 4'd0;
            case (state_q)
              S_START: begin
                state_q <= S_DATA;
                idx_q   <= 2'd0;
                txd_q   <= nib_q[0];
              end
              S_DATA: begin
                if (idx_q == 2'd3) begin
`ifdef TX_PARITY_EN
                  state_q <= S_PAR;
                  txd_q   <= par_q;
`else
                  state_q <= S_STOP;
                  txd_q   <= 1'b1;
`endif
                end else begin
                  idx_q <= idx_q + 2'd1;
                  txd_q <= nib_q[idx_q + 2'd1];
                end
              end
`ifdef TX_PARITY_EN
              S_PAR: begin
                state_q <= S_STOP;
                txd_q   <= 1'b1;
              end
`endif
              default: begin
                // End of the stop bit: back to idle with a single done pulse.
                state_q <= S_IDLE;
                txd_q   <= 1'b1;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign io_out = {nib_q, par_q, done_q, busy_q, txd_q};

endmodule

// File: tb/tb_tt_serial_tx_nibble.sv
// -----------------------------------------------------------------------------
// tb_tt_serial_tx_nibble
//
// Self-checking bench for tt_serial_tx_nibble with DIV=4. Works with or
// without TX_PARITY_EN; expected frames for both builds are written out by
// hand in the vector table.
// -----------------------------------------------------------------------------
module tb_tt_serial_tx_nibble;

  localparam int DIV = 4;
`ifdef TX_PARITY_EN
  localparam int FB = 7;
`else
  localparam int FB = 6;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] data  = 4'h0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {data, 1'b0, start, rst_n, clk};

  tt_serial_tx_nibble #(.DIV(DIV)) dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Frame bits listed with bit n (0 = start bit) at vector index n.
  typedef struct {
    logic [3:0] nib;
    logic [6:0] bits_p;   // start, d0..d3, parity, stop
    logic [5:0] bits_np;  // start, d0..d3, stop
    logic       par;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [6:0] frame_bits(input vec_t v);
`ifdef TX_PARITY_EN
    return v.bits_p;
`else
    return {1'b0, v.bits_np};
`endif
  endfunction

  // Drive a start edge with the given nibble; accepted on the next posedge.
  task automatic launch(input logic [3:0] nib);
    @(negedge clk);
    data  = nib;
    start = 1'b1;
  endtask

  // Called right after launch/accept; checks every cycle of the frame and
  // returns at the negedge of the done cycle, having checked it.
  task automatic expect_frame(input string tag, input logic [3:0] nib,
                              input logic [6:0] bits, input logic par,
                              input int retrig_at);
    for (int c = 0; c < FB * DIV; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d", tag, c), io_out, {nib, par, 1'b0, 1'b1, bits[c / DIV]});
      if (c == 0) begin
        start = 1'b0;
        data  = ~nib;  // the nibble must be sampled only on the accept edge
      end
      if (c == retrig_at) start = 1'b1;
    end
    @(negedge clk);
    check({tag, " done"}, io_out, {nib, par, 3'b101});
  endtask

  int busy_seen;
  int done_seen;

  initial begin
    //               nib    parity frame   no-parity   par
    vecs[0] = '{4'hA, 7'b1010100, 6'b110100, 1'b0};
    vecs[1] = '{4'h7, 7'b1101110, 6'b101110, 1'b1};
    vecs[2] = '{4'h0, 7'b1000000, 6'b100000, 1'b0};
    vecs[3] = '{4'hF, 7'b1011110, 6'b111110, 1'b0};
    vecs[4] = '{4'h5, 7'b1001010, 6'b101010, 1'b0};
    vecs[5] = '{4'h1, 7'b1100010, 6'b100010, 1'b1};

    // Reset with arbitrary inputs, start already high.
    rst_n = 1'b0;
    start = 1'b1;
    data  = 4'hC;
    repeat (2) @(negedge clk);
    check("reset state", io_out, 8'b0000_0001);
    rst_n = 1'b1;
    busy_seen = 0;
    for (int i = 0; i < 8 * DIV; i++) begin
      @(negedge clk);
      if (io_out[1]) busy_seen++;
    end
    check("start high at reset release", 8'(busy_seen), 8'd0);
    check("idle after reset release", io_out, 8'b0000_0001);
    start = 1'b0;
    @(negedge clk);

    // Table-driven frames.
    foreach (vecs[i]) begin
      launch(vecs[i].nib);
      expect_frame($sformatf("vec%0d", i), vecs[i].nib, frame_bits(vecs[i]), vecs[i].par, -1);
      @(negedge clk);
      check($sformatf("vec%0d idle", i), io_out, {vecs[i].nib, vecs[i].par, 3'b001});
    end

    // Second edge at cycle 10, then held high: ignored, single done.
    launch(4'hA);
    expect_frame("retrig", 4'hA, frame_bits(vecs[0]), 1'b0, 9);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("retrig idle%0d", i), io_out, {4'hA, 1'b0, 3'b001});
    end
    start = 1'b0;
    @(negedge clk);

    // Back-to-back: edge presented in the done cycle.
    launch(4'h7);
    expect_frame("b2b first", 4'h7, frame_bits(vecs[1]), 1'b1, -1);
    data  = 4'h3;
    start = 1'b1;
`ifdef TX_PARITY_EN
    expect_frame("b2b second", 4'h3, 7'b1000110, 1'b0, -1);
`else
    expect_frame("b2b second", 4'h3, 7'b0100110, 1'b0, -1);
`endif
    @(negedge clk);
    check("b2b idle", io_out, {4'h3, 1'b0, 3'b001});

    // Reset during bit 3 aborts the frame without a done pulse.
    launch(4'hA);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 0) start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("abort reset", io_out, 8'b0000_0001);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (io_out[2]) done_seen++;
    end
    check("abort no done", 8'(done_seen), 8'd0);
    check("abort idle", io_out, 8'b0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
